// File: rtl/rsc_trellis_encoder.sv
// 8-state recursive systematic convolutional encoder (g0=13, g1=15 octal) with
// 3-step trellis termination; emits one registered (sys, parity) pair per step.
module rsc_trellis_encoder #(
    parameter int FRAME_LEN = 61,
    parameter int CNT_W     = 6
) (
    input  logic Turbo_clk,
    input  logic rst,
    input  logic start,
    input  logic in_bit,
    input  logic in_valid,
    output logic in_ready,
    output logic sys,
    output logic parity,
    output logic Data_Valid,
    output logic enc_busy,
    output logic enc_done
);

    typedef enum logic [1:0] {
        IDLE,
        ENCODE,
        TAIL
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [2:0]       trellis_q, trellis_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sys_q, sys_d;
    logic             parity_q, parity_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             step_u;
    logic             fb;
    logic             par;

    // trellis_q = {s1, s2, s3}, s1 newest
    always_comb begin
        fb  = step_u ^ trellis_q[1] ^ trellis_q[0];
        par = fb ^ trellis_q[2] ^ trellis_q[0];
    end

    always_comb begin
        fsm_d     = fsm_q;
        trellis_d = trellis_q;
        cnt_d     = cnt_q;
        sys_d     = 1'b0;
        parity_d  = 1'b0;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        step_u    = 1'b0;
        busy_d    = (fsm_q != IDLE);

        case (fsm_q)
            IDLE: begin
                if (start) begin
                    fsm_d     = ENCODE;
                    cnt_d     = '0;
                    trellis_d = 3'b000;
                end
            end
            ENCODE: begin
                if (in_valid) begin
                    step_u    = in_bit;
                    trellis_d = {fb, trellis_q[2:1]};
                    sys_d     = step_u;
                    parity_d  = par;
                    valid_d   = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        fsm_d = TAIL;
                        cnt_d = '0;
                    end
                end
            end
            TAIL: begin
                // Choosing u = s2^s3 zeroes the feedback, flushing the register to 000
                step_u    = trellis_q[1] ^ trellis_q[0];
                trellis_d = {fb, trellis_q[2:1]};
                sys_d     = step_u;
                parity_d  = par;
                valid_d   = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(2)) begin
                    fsm_d  = IDLE;
                    cnt_d  = '0;
                    done_d = 1'b1;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Turbo_clk) begin
        if (!rst) begin
            fsm_q     <= IDLE;
            trellis_q <= 3'b000;
            cnt_q     <= '0;
            sys_q     <= 1'b0;
            parity_q  <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            trellis_q <= trellis_d;
            cnt_q     <= cnt_d;
            sys_q     <= sys_d;
            parity_q  <= parity_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign in_ready   = (fsm_q == ENCODE);
    assign sys        = sys_q;
    assign parity     = parity_q;
    assign Data_Valid = valid_q;
    assign enc_busy   = busy_q;
    assign enc_done   = done_q;

endmodule

// File: tb/tb_rsc_trellis_encoder.sv
// Scoreboard bench for rsc_trellis_encoder: two instances (FRAME_LEN 4 and 61), expected
// pairs come from a polynomial-level model of the g0=13 / g1=15 recursive code.
module tb_rsc_trellis_encoder;

    logic clk;
    logic rst;
    logic st [2];
    logic ib [2];
    logic inv [2];
    logic rdy [2];
    logic sy [2];
    logic pa [2];
    logic dv [2];
    logic bz [2];
    logic dn [2];

    logic [3:0] q0 [$];
    logic [3:0] q1 [$];
    int         vtime [$];
    int         vcnt [2];
    int         cyc;
    int         checks;
    int         passes;

    rsc_trellis_encoder #(.FRAME_LEN(4), .CNT_W(6)) u_dut4 (
        .Turbo_clk (clk),
        .rst       (rst),
        .start     (st[0]),
        .in_bit    (ib[0]),
        .in_valid  (inv[0]),
        .in_ready  (rdy[0]),
        .sys       (sy[0]),
        .parity    (pa[0]),
        .Data_Valid(dv[0]),
        .enc_busy  (bz[0]),
        .enc_done  (dn[0])
    );

    rsc_trellis_encoder #(.FRAME_LEN(61), .CNT_W(6)) u_dut61 (
        .Turbo_clk (clk),
        .rst       (rst),
        .start     (st[1]),
        .in_bit    (ib[1]),
        .in_valid  (inv[1]),
        .in_ready  (rdy[1]),
        .sys       (sy[1]),
        .parity    (pa[1]),
        .Data_Valid(dv[1]),
        .enc_busy  (bz[1]),
        .enc_done  (dn[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic pushExp(input int d, input logic [3:0] v);
        if (d == 0) q0.push_back(v);
        else q1.push_back(v);
    endtask

    // Feedback sequence a[k] = u[k]^a[k-2]^a[k-3]; parity = a[k]^a[k-1]^a[k-3].
    // Tail inputs are chosen so that a[k] = 0. Entries are {busy, done, sys, parity}.
    task automatic pushModel(input int d, input bit bits[$], input int keep);
        bit         a [$];
        logic [3:0] out [$];
        bit         u;
        bit         ak;
        a = '{1'b0, 1'b0, 1'b0};
        for (int k = 0; k < bits.size() + 3; k++) begin
            int n = a.size();
            if (k < bits.size()) u = bits[k];
            else u = a[n-2] ^ a[n-3];
            ak = u ^ a[n-2] ^ a[n-3];
            out.push_back({1'b1, (k == bits.size() + 2), u, ak ^ a[n-1] ^ a[n-3]});
            a.push_back(ak);
        end
        for (int i = 0; i < out.size(); i++)
            if (keep < 0 || i < keep) pushExp(d, out[i]);
    endtask

    task automatic monDut(input int d);
        logic [3:0] want;
        if (dv[d] === 1'b1) begin
            vcnt[d]++;
            if (d == 0) vtime.push_back(cyc);
            if (qsize(d) == 0) begin
                checkOutput("unexpected Data_Valid", 32'd1, 32'd0);
            end else begin
                if (d == 0) want = q0.pop_front();
                else want = q1.pop_front();
                checkOutput((d == 0) ? "dut4 {busy,done,sys,par}" : "dut61 {busy,done,sys,par}",
                            {28'd0, bz[d], dn[d], sy[d], pa[d]}, {28'd0, want});
            end
        end else if (dn[d] === 1'b1) begin
            checkOutput("enc_done without Data_Valid", 32'd1, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        monDut(0);
        monDut(1);
    end

    task automatic applyStimulus(input int d, input bit b, input int gap, input bit spam);
        int n;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            inv[d] = 1'b0;
            if (spam) st[d] = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        inv[d] = 1'b1;
        ib[d]  = b;
        if (spam) st[d] = 1'($urandom_range(0, 1));
        n = 0;
        while (rdy[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkOutput("in_ready timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    task automatic startFrame(input int d);
        vcnt[d] = 0;
        if (d == 0) vtime.delete();
        @(negedge clk);
        st[d] = 1'b1;
        @(negedge clk);
        st[d] = 1'b0;
    endtask

    task automatic endInputs(input int d);
        @(negedge clk);
        inv[d] = 1'b0;
        st[d]  = 1'b0;
    endtask

    task automatic waitDrain(input int d, input int frame_len);
        int n = 0;
        while (qsize(d) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", qsize(d), 32'd0);
        checkOutput("Data_Valid count", vcnt[d], frame_len + 3);
    endtask

    task automatic checkIdleOutputs(input int d);
        checkOutput("in_ready idle", {31'd0, rdy[d]}, 32'd0);
        checkOutput("sys idle", {31'd0, sy[d]}, 32'd0);
        checkOutput("parity idle", {31'd0, pa[d]}, 32'd0);
        checkOutput("Data_Valid idle", {31'd0, dv[d]}, 32'd0);
        checkOutput("enc_busy idle", {31'd0, bz[d]}, 32'd0);
        checkOutput("enc_done idle", {31'd0, dn[d]}, 32'd0);
    endtask

    // Known answer for 1,0,0,0 on the FRAME_LEN=4 instance
    task automatic pushKnown4();
        bit sys_lit [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) pushExp(0, {1'b1, (i == 6), sys_lit[i], 1'b1});
    endtask

    task automatic runKnown4(input int gap);
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        startFrame(0);
        pushKnown4();
        for (int i = 0; i < 4; i++) applyStimulus(0, pat[i], (i == 0) ? 0 : gap, 1'b0);
        endInputs(0);
        waitDrain(0, 4);
    endtask

    task automatic runRandom(input int d, input int frame_len);
        bit fr [$];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            inv[d] = 1'b1;
            ib[d]  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        inv[d] = 1'b0;
        for (int i = 0; i < frame_len; i++) fr.push_back(1'($urandom_range(0, 1)));
        startFrame(d);
        pushModel(d, fr, -1);
        for (int i = 0; i < frame_len; i++) applyStimulus(d, fr[i], $urandom_range(0, 2), 1'b1);
        endInputs(d);
        waitDrain(d, frame_len);
    endtask

    initial begin
        bit zeros [$];
        bit pat4 [$];
        checks = 0;
        passes = 0;
        cyc    = 0;
        rst    = 1'b0;
        for (int d = 0; d < 2; d++) begin
            st[d]   = 1'b0;
            ib[d]   = 1'b0;
            inv[d]  = 1'b0;
            vcnt[d] = 0;
        end

        $display("[TB] reset with toggling inputs");
        repeat (2) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                st[d]  = ~st[d];
                inv[d] = ~inv[d];
                ib[d]  = 1'b1;
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) checkIdleOutputs(d);
        for (int d = 0; d < 2; d++) begin
            st[d]  = 1'b0;
            inv[d] = 1'b0;
            ib[d]  = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] FRAME_LEN=4, 1,0,0,0 back-to-back");
        runKnown4(0);
        checkOutput("back-to-back span", vtime[6] - vtime[0], 32'd6);

        $display("[TB] FRAME_LEN=61, all-zero frame");
        for (int i = 0; i < 61; i++) zeros.push_back(1'b0);
        startFrame(1);
        pushModel(1, zeros, -1);
        for (int i = 0; i < 61; i++) applyStimulus(1, 1'b0, 0, 1'b0);
        endInputs(1);
        waitDrain(1, 61);

        $display("[TB] FRAME_LEN=4 with 2-cycle input gaps");
        runKnown4(2);
        checkOutput("encode gap 0-1", vtime[1] - vtime[0], 32'd3);
        checkOutput("encode gap 2-3", vtime[3] - vtime[2], 32'd3);
        checkOutput("last info to tail", vtime[4] - vtime[3], 32'd1);
        checkOutput("tail contiguous", vtime[6] - vtime[4], 32'd2);

        $display("[TB] reset after second accepted bit");
        pat4 = '{1'b1, 1'b0, 1'b0, 1'b0};
        startFrame(0);
        pushModel(0, pat4, 2);
        applyStimulus(0, 1'b1, 0, 1'b0);
        applyStimulus(0, 1'b0, 0, 1'b0);
        @(negedge clk);
        rst    = 1'b0;
        inv[0] = 1'b0;
        @(negedge clk);
        checkIdleOutputs(0);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("aborted frame outputs", vcnt[0], 32'd2);
        checkOutput("aborted frame queue", qsize(0), 32'd0);
        runKnown4(0);

        $display("[TB] random frames with gaps and start pulses while busy");
        for (int f = 0; f < 3; f++) runRandom(1, 61);
        for (int f = 0; f < 4; f++) runRandom(0, 4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
